i2c_target_regs: RTL and testbench

//  Synthesizable I2C target (responder) for the tinyQV I2C master: 7-bit address, 8-entry register bank.

---
 rtl/i2c_pkg.sv | 23 ++
 rtl/i2c_bus_sync.sv | 48 ++++
 rtl/i2c_target_regs.sv | 184 ++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-bank target: FSM state encoding and bus level constants.
`default_nettype none

package i2c_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADDR     = 3'd1,
    S_ADDR_ACK = 3'd2,
    S_WR_PTR   = 3'd3,
    S_WR_DATA  = 3'd4,
    S_RD_BYTE  = 3'd5,
    S_RD_ACK   = 3'd6,
    S_IGNORE   = 3'd7
  } state_t;

  localparam logic ACK_LVL  = 1'b0;
  localparam logic NACK_LVL = 1'b1;
  localparam int   RW_BIT   = 0;

endpackage

`default_nettype wire

// File: rtl/i2c_bus_sync.sv
// Synchronizes SCL/SDA into the clk domain and flags SCL edges plus START/STOP conditions.
`default_nettype none

module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sr;
  logic [SYNC_STAGES-1:0] sda_sr;
  logic                   scl_h;
  logic                   sda_h;
  logic                   scl_s;

  // Idle bus level is high, so reset the chain high to avoid phantom edges.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_h  <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
      scl_h  <= scl_sr[SYNC_STAGES-1];
      sda_h  <= sda_sr[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sr[SYNC_STAGES-1];
  assign sda       = sda_sr[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_h;
  assign scl_fall  = ~scl_s & scl_h;
  assign start_det = scl_s & scl_h & sda_h & ~sda;
  assign stop_det  = scl_s & scl_h & ~sda_h & sda;

endmodule

`default_nettype wire

// File: rtl/i2c_target_regs.sv
// I2C target with a pointer-addressed register bank; host-side preload port, open-drain SDA via sda_oe.
`default_nettype none

module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h44,
  parameter int         NREGS       = 8,
  parameter int         SYNC_STAGES = 2,
  localparam int        PW          = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  input  logic          host_wr_en,
  input  logic [PW-1:0] host_wr_addr,
  input  logic [7:0]    host_wr_data,
  output logic          busy,
  output logic          wr_strobe,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          stop_seen
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda       (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t        state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic          ack_ph, ack_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    tx, tx_n;
  logic [PW-1:0] ptr, ptr_n;
  logic [7:0]    rx_byte;
  logic          i2c_we;
  logic          drive;
  logic          fall_d;
  logic [7:0]    bank [NREGS];

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ack_n   = ack_ph;
    shreg_n = shreg;
    tx_n    = tx;
    ptr_n   = ptr;
    i2c_we  = 1'b0;
    rx_byte = {shreg[6:0], sda_s};

    if (stop_det) begin
      state_n = S_IDLE;
      ack_n   = 1'b0;
    end else if (start_det) begin
      state_n = S_ADDR;
      cnt_n   = 4'd0;
      ack_n   = 1'b0;
    end else begin
      case (state)
        S_ADDR: begin
          if (scl_rise && cnt < 4'd8) begin
            shreg_n = rx_byte;
            cnt_n   = cnt + 4'd1;
          end else if (scl_fall && cnt == 4'd8) begin
            state_n = (shreg[7:1] == TARGET_ADDR) ? S_ADDR_ACK : S_IGNORE;
          end
        end
        S_ADDR_ACK: begin
          if (scl_fall) begin
            cnt_n = 4'd0;
            if (shreg[RW_BIT]) begin
              state_n = S_RD_BYTE;
              tx_n    = bank[ptr];
            end else begin
              state_n = S_WR_PTR;
            end
          end
        end
        S_WR_PTR, S_WR_DATA: begin
          // ack_ph marks the 9th clock, where the target holds SDA low and nothing is shifted.
          if (scl_rise && !ack_ph && cnt < 4'd8) begin
            shreg_n = rx_byte;
            cnt_n   = cnt + 4'd1;
            if (state == S_WR_DATA && cnt == 4'd7) i2c_we = 1'b1;
          end else if (scl_fall) begin
            if (ack_ph) begin
              ack_n   = 1'b0;
              cnt_n   = 4'd0;
              state_n = S_WR_DATA;
            end else if (cnt == 4'd8) begin
              ack_n = 1'b1;
              ptr_n = (state == S_WR_PTR) ? shreg[PW-1:0] : ptr + PW'(1);
            end
          end
        end
        S_RD_BYTE: begin
          if (scl_rise && cnt < 4'd8) begin
            cnt_n = cnt + 4'd1;
          end else if (scl_fall) begin
            if (cnt == 4'd8) state_n = S_RD_ACK;
            else             tx_n    = {tx[6:0], 1'b0};
          end
        end
        S_RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == NACK_LVL) state_n = S_IGNORE;
            else                   ptr_n   = ptr + PW'(1);
          end else if (scl_fall) begin
            state_n = S_RD_BYTE;
            cnt_n   = 4'd0;
            tx_n    = bank[ptr];
          end
        end
        default: ;
      endcase
    end

    drive = (state == S_ADDR_ACK)
          || (((state == S_WR_PTR) || (state == S_WR_DATA)) && ack_ph)
          || ((state == S_RD_BYTE) && !tx[7]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      ack_ph    <= 1'b0;
      shreg     <= 8'h00;
      tx        <= 8'h00;
      ptr       <= '0;
      fall_d    <= 1'b0;
      sda_oe    <= 1'b0;
      stop_seen <= 1'b0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= 8'h00;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      ack_ph    <= ack_n;
      shreg     <= shreg_n;
      tx        <= tx_n;
      ptr       <= ptr_n;
      fall_d    <= scl_fall;
      stop_seen <= stop_det;
      wr_strobe <= i2c_we;
      if (i2c_we) begin
        wr_addr <= ptr;
        wr_data <= rx_byte;
      end
      // SDA changes only one clk after the synchronized SCL fall, giving hold margin.
      if (stop_det)    sda_oe <= 1'b0;
      else if (fall_d) sda_oe <= drive;
    end
  end

  // I2C commit is sequenced after the host write so it wins on an index collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) bank[i] <= 8'h00;
    end else begin
      if (host_wr_en) bank[host_wr_addr] <= host_wr_data;
      if (wr_strobe)  bank[wr_addr]      <= wr_data;
    end
  end

  assign busy = (state == S_ADDR_ACK) || (state == S_WR_PTR) || (state == S_WR_DATA)
             || (state == S_RD_BYTE)  || (state == S_RD_ACK);

endmodule

`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master with immediate-assertion checks.
`default_nettype none

module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int H = 10;
  localparam int Q = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       host_wr_en = 1'b0;
  logic [2:0] host_wr_addr = 3'd0;
  logic [7:0] host_wr_data = 8'h00;
  logic       sda_oe, busy, wr_strobe, stop_seen;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_bus = sda_m & ~sda_oe;

  int vecs = 0;
  int errs = 0;
  int stop_cnt = 0;
  logic oe_seen = 1'b0;
  logic [2:0] log_a [$];
  logic [7:0] log_d [$];

  i2c_target_regs #(.TARGET_ADDR(7'h44), .NREGS(8), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .scl_i        (scl_m),
    .sda_i        (sda_bus),
    .sda_oe       (sda_oe),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .busy         (busy),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .stop_seen    (stop_seen)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stop_seen) stop_cnt++;
    if (sda_oe) oe_seen = 1'b1;
    if (wr_strobe) begin
      log_a.push_back(wr_addr);
      log_d.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(H);
    sda_m = 1'b0; wclk(H);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(H);
    sda_m = 1'b1; wclk(H);
  endtask

  task automatic send8(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i]; wclk(H);
      scl_m = 1'b1; wclk(H);
      scl_m = 1'b0; wclk(Q);
    end
  endtask

  task automatic clk9(input logic drv, output logic smp);
    sda_m = drv;  wclk(H);
    scl_m = 1'b1; wclk(H/2);
    smp = sda_bus; wclk(H/2);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send8(b);
    clk9(1'b1, ack);
  endtask

  task automatic read_byte(input logic ack_bit, output logic [7:0] b);
    logic dummy;
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      wclk(H);
      scl_m = 1'b1; wclk(H/2);
      b[i] = sda_bus; wclk(H/2);
      scl_m = 1'b0; wclk(Q);
    end
    clk9(ack_bit, dummy);
  endtask

  task automatic host_write(input logic [2:0] a, input logic [7:0] d);
    host_wr_addr = a; host_wr_data = d; host_wr_en = 1'b1;
    wclk(1);
    host_wr_en = 1'b0;
  endtask

  initial begin
    logic       ack, hit;
    logic [7:0] rb;
    int         n0, s0;
    logic [7:0] exp_rd [6];
    exp_rd[0] = 8'hD1; exp_rd[1] = 8'hD2; exp_rd[2] = 8'hD3;
    exp_rd[3] = 8'hD4; exp_rd[4] = 8'hD5; exp_rd[5] = 8'hD6;

    wclk(5);
    rst_n = 1'b1;
    wclk(2);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", wr_strobe, 0);
    check("rst_stop_seen", stop_seen, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);

    // Matching address, write direction
    i2c_start();
    send_byte(8'h88, ack);
    check("addr88_ack", ack, ACK_LVL);
    check("addr88_busy", busy, 1);
    s0 = stop_cnt;
    i2c_stop();
    check("addr88_stop_busy", busy, 0);
    check("addr88_stop_seen", stop_cnt - s0, 1);

    // Non-matching address
    oe_seen = 1'b0;
    i2c_start();
    send_byte(8'h8A, ack);
    check("addr8A_nack", ack, NACK_LVL);
    check("addr8A_busy", busy, 0);
    check("addr8A_oe_quiet", oe_seen, 0);
    i2c_stop();

    // Pointer write then two data bytes
    n0 = log_a.size();
    s0 = stop_cnt;
    i2c_start();
    send_byte(8'h88, ack); check("wr_ack_addr", ack, 0);
    send_byte(8'h02, ack); check("wr_ack_ptr", ack, 0);
    send_byte(8'hA5, ack); check("wr_ack_d0", ack, 0);
    send_byte(8'h5A, ack); check("wr_ack_d1", ack, 0);
    i2c_stop();
    check("wr_strobe_count", log_a.size() - n0, 2);
    if (log_a.size() - n0 == 2) begin
      check("wr_addr0", log_a[n0], 3'd2);
      check("wr_data0", log_d[n0], 8'hA5);
      check("wr_addr1", log_a[n0+1], 3'd3);
      check("wr_data1", log_d[n0+1], 8'h5A);
    end
    check("wr_stop_seen", stop_cnt - s0, 1);

    // Readback of the written bytes from pointer 2
    i2c_start();
    send_byte(8'h88, ack);
    send_byte(8'h02, ack);
    i2c_start();
    send_byte(8'h89, ack); check("rb_ack", ack, 0);
    read_byte(1'b0, rb); check("rb_bank2", rb, 8'hA5);
    read_byte(1'b1, rb); check("rb_bank3", rb, 8'h5A);
    i2c_stop();

    // Host preload and six-byte sequential read
    for (int i = 0; i < 6; i++) host_write(3'(i), exp_rd[i]);
    i2c_start();
    send_byte(8'h88, ack);
    send_byte(8'h00, ack);
    i2c_start();
    send_byte(8'h89, ack); check("rd6_ack", ack, 0);
    for (int i = 0; i < 6; i++) begin
      read_byte((i == 5) ? 1'b1 : 1'b0, rb);
      check($sformatf("rd6_byte%0d", i), rb, exp_rd[i]);
    end
    check("rd6_ignore_busy", busy, 0);
    i2c_stop();

    // Pointer wrap from index 7
    host_write(3'd7, 8'h77);
    i2c_start();
    send_byte(8'h88, ack);
    send_byte(8'h07, ack);
    i2c_start();
    send_byte(8'h89, ack);
    read_byte(1'b0, rb); check("wrap_b7", rb, 8'h77);
    read_byte(1'b0, rb); check("wrap_b0", rb, 8'hD1);
    read_byte(1'b1, rb); check("wrap_b1", rb, 8'hD2);
    i2c_stop();

    // Host write colliding with the I2C write to index 3
    hit = 1'b0;
    i2c_start();
    send_byte(8'h88, ack);
    send_byte(8'h03, ack);
    fork
      send_byte(8'h22, ack);
      begin
        for (int k = 0; k < 400 && wr_strobe !== 1'b1; k++) @(negedge clk);
        if (wr_strobe === 1'b1) begin
          hit = 1'b1;
          host_wr_addr = 3'd3; host_wr_data = 8'h11; host_wr_en = 1'b1;
          @(posedge clk); #1;
          host_wr_en = 1'b0;
        end
      end
    join
    i2c_stop();
    check("coll_strobe_seen", hit, 1);
    i2c_start();
    send_byte(8'h88, ack);
    send_byte(8'h03, ack);
    i2c_start();
    send_byte(8'h89, ack);
    read_byte(1'b1, rb); check("coll_bank3", rb, 8'h22);
    i2c_stop();

    // Reset while the target holds the address ACK
    i2c_start();
    send8(8'h88);
    wclk(4);
    check("mid_ack_drive", sda_oe, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_release", sda_oe, 0);
    wclk(2);
    rst_n = 1'b1;
    wclk(2);
    i2c_stop();
    i2c_start();
    send_byte(8'h88, ack);
    check("post_rst_ack", ack, 0);
    check("post_rst_busy", busy, 1);
    i2c_stop();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

`default_nettype wire
